// File: rtl/bitwise_logic_seq_if.sv
// Operand/result bundle for the sliced bitwise logic unit.
// Handshake: start is a request sampled only while the unit is idle; done is a one-cycle completion pulse.
interface bitwise_logic_seq_if #(
  parameter int N = 32
);
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] C;
  logic         parity;
  logic         zero;

  modport master (
    output start, op, A, B,
    input  busy, done, C, parity, zero
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, C, parity, zero
  );
endinterface

// File: rtl/bitwise_logic_seq.sv
// Multi-cycle bitwise logic unit: latches operands on start and processes W bits per clock, LSB-first.
// Result, parity and zero update only on the completion edge.
module bitwise_logic_seq #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst,
  bitwise_logic_seq_if.slave bus,
  output logic [1:0]         dbg_state
);
  localparam int K  = N / W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if (N % W != 0) begin : g_bad_w
    $error("bitwise_logic_seq: N must be a multiple of W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_q, b_q;
  logic [2:0]    op_q;
  logic [N-1:0]  res;
  logic [N-1:0]  res_next;
  logic [N-1:0]  c_q;
  logic          parity_q, zero_q;
  logic [W-1:0]  a_s, b_s, slice;
  logic [N+W-1:0] res_cat;
  logic          last;

  assign last = (cnt == CW'(K - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = BUSY;
      BUSY:    if (last)      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands shift right every slice, so the current slice is always the low W bits.
  assign a_s = a_q[W-1:0];
  assign b_s = b_q[W-1:0];

  always_comb begin
    slice = '0;
    case (op_q)
      3'b000: slice = a_s & b_s;
      3'b001: slice = a_s | b_s;
      3'b010: slice = a_s ^ b_s;
      3'b011: slice = ~(a_s | b_s);
      3'b100: slice = ~(a_s ^ b_s);
      3'b101: slice = ~(a_s & b_s);
      3'b110: slice = ~a_s;
      3'b111: slice = a_s & ~b_s;
      default: slice = '0;
    endcase
  end

  // New slice enters at the top; after K slices slice 0 sits at the bottom. Also correct for K == 1.
  assign res_cat  = {slice, res};
  assign res_next = N'(res_cat >> W);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res      <= '0;
      c_q      <= '0;
      parity_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q  <= bus.A;
            b_q  <= bus.B;
            op_q <= bus.op;
            cnt  <= '0;
          end
        end
        BUSY: begin
          res <= res_next;
          a_q <= a_q >> W;
          b_q <= b_q >> W;
          if (last) begin
            c_q      <= res_next;
            parity_q <= ^res_next;
            zero_q   <= (res_next == '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == BUSY);
  assign bus.done   = (state == DONE);
  assign bus.C      = c_q;
  assign bus.parity = parity_q;
  assign bus.zero   = zero_q;
  assign dbg_state  = state;
endmodule
